// File: rtl/mbinit_pkg.sv
// Shared definitions for the MBINIT.PARAM exchange: sideband message codes
// and the initiator state encoding.
package mbinit_pkg;

   localparam logic [3:0] MSG_NONE = 4'b0000;
   localparam logic [3:0] MSG_REQ  = 4'b0001;
   localparam logic [3:0] MSG_RESP = 4'b0010;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND_REQ  = 3'd1,
      ST_WAIT_TX   = 3'd2,
      ST_WAIT_RESP = 3'd3,
      ST_CHECK     = 3'd4,
      ST_DONE      = 3'd5,
      ST_ERROR     = 3'd6
   } init_state_e;

endpackage

// File: rtl/mbinit_param_timer.sv
// Response timeout counter: cleared while idle, counts while enabled and
// flags the terminal cycle TIMEOUT_CYC-1.
module mbinit_param_timer #(
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 11
) (
   input  logic CLK,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1'b1);

   logic [CNT_W-1:0] count;

   // Count up while enabled; saturate at the terminal value.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != TC_VAL)) begin
         count <= count + ONE;
      end else begin
         count <= count;
      end
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/mbinit_param_negotiator.sv
// MBINIT.PARAM exchange engine: initiator FSM (REQ/RESP with timeout and retry),
// concurrent responder path and a single-message sideband TX arbiter.
module mbinit_param_negotiator
   import mbinit_pkg::*;
#(
   parameter int RATE_W      = 3,
   parameter int VSWING_W    = 5,
   parameter int TIMEOUT_CYC = 1024,
   parameter int MAX_RETRY   = 2,
   parameter int CNT_W       = 11
) (
   input  logic                CLK,
   input  logic                rst_n,
   input  logic                i_start_en,
   input  logic [VSWING_W-1:0] i_local_vswing,
   input  logic [RATE_W-1:0]   i_local_max_rate,
   input  logic                i_local_clk_mode,
   input  logic                i_local_phase_clk,
   input  logic [3:0]          i_rx_msg,
   input  logic                i_rx_msg_valid,
   input  logic [RATE_W-1:0]   i_rx_max_rate,
   input  logic                i_rx_clk_mode,
   input  logic                i_rx_phase_clk,
   input  logic                i_sb_busy,
   input  logic                i_sb_busy_fall,
   output logic                o_tx_valid,
   output logic [3:0]          o_tx_msg,
   output logic [VSWING_W-1:0] o_tx_vswing,
   output logic [RATE_W-1:0]   o_tx_max_rate,
   output logic                o_tx_clk_mode,
   output logic                o_tx_phase_clk,
   output logic [RATE_W-1:0]   o_final_max_rate,
   output logic                o_done,
   output logic                o_train_error_req,
   output logic [1:0]          o_retry_cnt
);

   localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

   function automatic logic [RATE_W-1:0] rate_min(input logic [RATE_W-1:0] a,
                                                  input logic [RATE_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   init_state_e state, next_state;

   logic [RATE_W-1:0] rx_rate;
   logic              rx_mode;
   logic              rx_phase;
   logic [RATE_W-1:0] partner_rate;
   logic              resp_pending;
   logic              resp_sent;
   logic              in_flight;
   logic              in_flight_resp;
   logic              retry_inc;
   logic              timeout;

   logic              active;
   logic              rx_req;
   logic              rx_resp;
   logic              can_launch;
   logic              launch_resp;
   logic              launch_req;
   logic [RATE_W-1:0] neg_rate;
   logic [RATE_W-1:0] resp_rate;
   logic              check_pass;

   // RX strobes are ignored while idle or aborted; RESP only counts when awaited.
   assign active      = i_start_en && (state != ST_IDLE);
   assign rx_req      = active && i_rx_msg_valid && (i_rx_msg == MSG_REQ);
   assign rx_resp     = i_start_en && (state == ST_WAIT_RESP) && i_rx_msg_valid
                        && (i_rx_msg == MSG_RESP);
   assign can_launch  = active && !i_sb_busy && !in_flight;
   assign launch_resp = can_launch && resp_pending;
   assign launch_req  = can_launch && !resp_pending && (state == ST_SEND_REQ);
   assign neg_rate    = rate_min(i_local_max_rate, rx_rate);
   assign resp_rate   = rate_min(i_local_max_rate, partner_rate);
   assign check_pass  = (neg_rate != '0) && (rx_mode == i_local_clk_mode)
                        && (rx_phase == i_local_phase_clk);

   mbinit_param_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) u_timer (
      .CLK   (CLK),
      .rst_n (rst_n),
      .clr   (state != ST_WAIT_RESP),
      .en    (state == ST_WAIT_RESP),
      .tc    (timeout)
   );

   // Initiator state register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Initiator next-state decode and retry request.
   always_comb begin
      next_state = state;
      retry_inc  = 1'b0;
      if (!i_start_en) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: next_state = ST_SEND_REQ;
            ST_SEND_REQ: begin
               if (launch_req) next_state = ST_WAIT_TX;
               else            next_state = ST_SEND_REQ;
            end
            ST_WAIT_TX: begin
               if (i_sb_busy_fall) next_state = ST_WAIT_RESP;
               else                next_state = ST_WAIT_TX;
            end
            ST_WAIT_RESP: begin
               if (rx_resp) begin
                  next_state = ST_CHECK;
               end else if (timeout) begin
                  if (o_retry_cnt < RETRY_MAX) begin
                     next_state = ST_SEND_REQ;
                     retry_inc  = 1'b1;
                  end else begin
                     next_state = ST_ERROR;
                  end
               end else begin
                  next_state = ST_WAIT_RESP;
               end
            end
            ST_CHECK: begin
               if (check_pass) next_state = ST_DONE;
               else            next_state = ST_ERROR;
            end
            ST_DONE:  next_state = ST_DONE;
            ST_ERROR: next_state = ST_ERROR;
            default:  next_state = ST_IDLE;
         endcase
      end
   end

   // Run-scoped flags: retry count, latched partner fields, responder progress.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         o_retry_cnt  <= 2'd0;
         rx_rate      <= '0;
         rx_mode      <= 1'b0;
         rx_phase     <= 1'b0;
         partner_rate <= '0;
         resp_pending <= 1'b0;
         resp_sent    <= 1'b0;
      end else if (!active) begin
         o_retry_cnt  <= 2'd0;
         rx_rate      <= '0;
         rx_mode      <= 1'b0;
         rx_phase     <= 1'b0;
         partner_rate <= '0;
         resp_pending <= 1'b0;
         resp_sent    <= 1'b0;
      end else begin
         if (retry_inc) o_retry_cnt <= o_retry_cnt + 2'd1;
         if (rx_resp) begin
            rx_rate  <= i_rx_max_rate;
            rx_mode  <= i_rx_clk_mode;
            rx_phase <= i_rx_phase_clk;
         end
         // A partner retry re-arms the response even after one went out.
         if (rx_req) begin
            partner_rate <= i_rx_max_rate;
            resp_pending <= 1'b1;
         end else if (launch_resp) begin
            resp_pending <= 1'b0;
         end
         if (i_sb_busy_fall && in_flight && in_flight_resp) resp_sent <= 1'b1;
      end
   end

   // In-flight tracking survives an abort: the sideband still owns the message.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         in_flight      <= 1'b0;
         in_flight_resp <= 1'b0;
      end else if (launch_resp || launch_req) begin
         in_flight      <= 1'b1;
         in_flight_resp <= launch_resp;
      end else if (i_sb_busy_fall) begin
         in_flight      <= 1'b0;
         in_flight_resp <= 1'b0;
      end else begin
         in_flight      <= in_flight;
         in_flight_resp <= in_flight_resp;
      end
   end

   // Registered TX launch, completion and error outputs.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         o_tx_valid        <= 1'b0;
         o_tx_msg          <= MSG_NONE;
         o_tx_vswing       <= '0;
         o_tx_max_rate     <= '0;
         o_tx_clk_mode     <= 1'b0;
         o_tx_phase_clk    <= 1'b0;
         o_final_max_rate  <= '0;
         o_done            <= 1'b0;
         o_train_error_req <= 1'b0;
      end else begin
         o_tx_valid     <= launch_resp || launch_req;
         o_tx_msg       <= launch_resp ? MSG_RESP : (launch_req ? MSG_REQ : MSG_NONE);
         o_tx_vswing    <= (launch_resp || launch_req) ? i_local_vswing : '0;
         o_tx_max_rate  <= launch_resp ? resp_rate : (launch_req ? i_local_max_rate : '0);
         o_tx_clk_mode  <= (launch_resp || launch_req) ? i_local_clk_mode : 1'b0;
         o_tx_phase_clk <= (launch_resp || launch_req) ? i_local_phase_clk : 1'b0;
         if (next_state == ST_DONE) begin
            o_final_max_rate <= (state == ST_CHECK) ? neg_rate : o_final_max_rate;
         end else begin
            o_final_max_rate <= '0;
         end
         o_done            <= (next_state == ST_DONE) && resp_sent;
         o_train_error_req <= (next_state == ST_ERROR) && (state != ST_ERROR);
      end
   end

endmodule
